// File: rtl/dds_pkg.sv
// Shared types and default widths for the DDS frequency-sweep controller.
//   state_t : sweep controller FSM states
//   wave_t  : waveform select; RSVD is passed through to the DDS unchanged
package dds_pkg;

    localparam int unsigned FTW_W_DEF   = 16;
    localparam int unsigned DWELL_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DWELL = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SQUARE = 2'd0,
        SAW    = 2'd1,
        TRI    = 2'd2,
        RSVD   = 2'd3
    } wave_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Sweep configuration handshake plus DDS-side outputs of the sweep controller.
//   master : host side (drives cfg_* and abort, observes status and DDS outputs)
//   slave  : dds_sweep_ctrl side
interface dds_sweep_ctrl_if #(
    parameter int unsigned FTW_W   = dds_pkg::FTW_W_DEF,
    parameter int unsigned DWELL_W = dds_pkg::DWELL_W_DEF
);
    import dds_pkg::*;

    logic               cfg_valid;
    logic               cfg_ready;
    logic [FTW_W-1:0]   cfg_ftw_start;
    logic [FTW_W-1:0]   cfg_ftw_stop;
    logic [FTW_W-1:0]   cfg_ftw_step;
    logic [DWELL_W-1:0] cfg_dwell;
    wave_t              cfg_wave;
    logic               cfg_loop;
    logic               abort;
    logic [FTW_W-1:0]   ftw;
    logic [1:0]         wave_sel;
    logic               ftw_load;
    logic               busy;
    logic               done;

    modport master (
        output cfg_valid, cfg_ftw_start, cfg_ftw_stop, cfg_ftw_step, cfg_dwell, cfg_wave,
               cfg_loop, abort,
        input  cfg_ready, ftw, wave_sel, ftw_load, busy, done
    );

    modport slave (
        input  cfg_valid, cfg_ftw_start, cfg_ftw_stop, cfg_ftw_step, cfg_dwell, cfg_wave,
               cfg_loop, abort,
        output cfg_ready, ftw, wave_sel, ftw_load, busy, done
    );

endinterface

// File: rtl/dds_dwell_timer.sv
// Loadable down-counter timing how long each sweep point is held.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_load         : load i_value (has priority over i_en)
//   i_en           : decrement, saturating at zero
//   i_value        : reload value
//   o_zero         : counter is zero
module dds_dwell_timer #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_en,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_zero
);

    logic [WIDTH-1:0] r_count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_value;
        end else if (i_en && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency-sweep controller. Latches a sweep config on the cfg handshake, then steps
// the tuning word from start to stop (inclusive) holding each point cfg_dwell+1 cycles.
//   DAC_clk, DAC_rst_n : clock, async active-low reset
//   io_bus (slave)     : cfg_* handshake, abort, ftw / wave_sel / ftw_load / busy / done
module dds_sweep_ctrl
    import dds_pkg::*;
#(
    parameter int unsigned FTW_W   = FTW_W_DEF,
    parameter int unsigned DWELL_W = DWELL_W_DEF
) (
    input  logic             DAC_clk,
    input  logic             DAC_rst_n,
    dds_sweep_ctrl_if.slave  io_bus
);

    state_t             r_state, w_state_next;
    logic [FTW_W-1:0]   r_ftw, w_ftw_next;
    logic               r_ftw_load, w_ftw_load_next;
    wave_t              r_wave;
    logic [FTW_W-1:0]   r_start, r_stop, r_step;
    logic [DWELL_W-1:0] r_dwell;
    logic               r_loop;

    logic               w_accept;
    logic               w_at_end;
    logic [FTW_W:0]     w_sum;
    logic [FTW_W-1:0]   w_ftw_stepped;
    logic               w_tmr_load, w_tmr_en, w_tmr_zero;

    assign w_accept = (r_state == IDLE) && io_bus.cfg_valid;
    assign w_at_end = (r_ftw >= r_stop);

    // One extra bit so a carry out of FTW_W counts as passing stop and saturates.
    assign w_sum         = {1'b0, r_ftw} + {1'b0, r_step};
    assign w_ftw_stepped = ((r_step == '0) || (w_sum > {1'b0, r_stop})) ? r_stop
                                                                          : w_sum[FTW_W-1:0];

    always_comb begin
        w_state_next    = r_state;
        w_ftw_next      = r_ftw;
        w_ftw_load_next = 1'b0;
        w_tmr_load      = 1'b0;
        w_tmr_en        = 1'b0;
        if ((r_state != IDLE) && io_bus.abort) begin
            // Mute the DDS by loading a zero tuning word.
            w_state_next    = IDLE;
            w_ftw_next      = '0;
            w_ftw_load_next = 1'b1;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_accept) w_state_next = LOAD;
                end
                LOAD: begin
                    w_state_next    = DWELL;
                    w_ftw_next      = r_start;
                    w_ftw_load_next = 1'b1;
                    w_tmr_load      = 1'b1;
                end
                DWELL: begin
                    if (!w_tmr_zero) begin
                        w_tmr_en = 1'b1;
                    end else if (!w_at_end) begin
                        w_ftw_next      = w_ftw_stepped;
                        w_ftw_load_next = 1'b1;
                        w_tmr_load      = 1'b1;
                    end else if (r_loop) begin
                        // Seamless restart: stay in DWELL, no LOAD cycle, no done.
                        w_ftw_next      = r_start;
                        w_ftw_load_next = 1'b1;
                        w_tmr_load      = 1'b1;
                    end else begin
                        w_state_next = DONE;
                    end
                end
                DONE: begin
                    w_state_next = IDLE;
                end
                default: begin
                    w_state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge DAC_clk or negedge DAC_rst_n) begin
        if (!DAC_rst_n) begin
            r_state    <= IDLE;
            r_ftw      <= '0;
            r_ftw_load <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_ftw      <= w_ftw_next;
            r_ftw_load <= w_ftw_load_next;
        end
    end

    // Config is captured only on the accepting edge; later input changes are ignored.
    always_ff @(posedge DAC_clk or negedge DAC_rst_n) begin
        if (!DAC_rst_n) begin
            r_wave  <= SQUARE;
            r_start <= '0;
            r_stop  <= '0;
            r_step  <= '0;
            r_dwell <= '0;
            r_loop  <= 1'b0;
        end else if (w_accept) begin
            r_wave  <= io_bus.cfg_wave;
            r_start <= io_bus.cfg_ftw_start;
            r_stop  <= io_bus.cfg_ftw_stop;
            r_step  <= io_bus.cfg_ftw_step;
            r_dwell <= io_bus.cfg_dwell;
            r_loop  <= io_bus.cfg_loop;
        end
    end

    dds_dwell_timer #(
        .WIDTH (DWELL_W)
    ) u_dwell_timer (
        .i_clk   (DAC_clk),
        .i_rst_n (DAC_rst_n),
        .i_load  (w_tmr_load),
        .i_en    (w_tmr_en),
        .i_value (r_dwell),
        .o_zero  (w_tmr_zero)
    );

    assign io_bus.ftw       = r_ftw;
    assign io_bus.wave_sel  = r_wave;
    assign io_bus.ftw_load  = r_ftw_load;
    assign io_bus.busy      = (r_state == LOAD) || (r_state == DWELL);
    assign io_bus.done      = (r_state == DONE);
    assign io_bus.cfg_ready = (r_state == IDLE);

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Self-checking bench for dds_sweep_ctrl. Expected cycle traces are built from the sweep
// rules (point list computed with plain integer arithmetic, then expanded by dwell time).
module tb_dds_sweep_ctrl;
    import dds_pkg::*;

    typedef struct packed {
        logic        ready;
        logic        busy;
        logic        done;
        logic        load;
        logic [1:0]  wave;
        logic [15:0] ftw;
    } exp_t;

    logic DAC_clk = 1'b0;
    logic DAC_rst_n;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [15:0] last_ftw = '0;
    exp_t exp_q[$];

    dds_sweep_ctrl_if #(.FTW_W(16), .DWELL_W(16)) bus ();

    dds_sweep_ctrl #(
        .FTW_W   (16),
        .DWELL_W (16)
    ) dut (
        .DAC_clk   (DAC_clk),
        .DAC_rst_n (DAC_rst_n),
        .io_bus    (bus)
    );

    always #5 DAC_clk = ~DAC_clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic scramble_cfg();
        bus.cfg_ftw_start = 16'($urandom);
        bus.cfg_ftw_stop  = 16'($urandom);
        bus.cfg_ftw_step  = 16'($urandom);
        bus.cfg_dwell     = 16'($urandom);
        bus.cfg_wave      = wave_t'($urandom_range(0, 3));
        bus.cfg_loop      = 1'($urandom);
    endtask

    // Expected trace: LOAD cycle, each point for dwell+1 cycles, DONE, then IDLE.
    task automatic build_trace(input int unsigned start, input int unsigned stop,
                               input int unsigned step, input int unsigned dwell,
                               input logic [1:0] wave);
        int unsigned pts[$];
        int unsigned p;
        exp_t e;
        pts.delete();
        exp_q.delete();
        p = start;
        pts.push_back(p);
        while (p < stop) begin
            p = (step == 0 || p + step > stop) ? stop : p + step;
            pts.push_back(p);
        end
        e = '{ready: 1'b0, busy: 1'b1, done: 1'b0, load: 1'b0, wave: wave, ftw: last_ftw};
        exp_q.push_back(e);
        foreach (pts[i]) begin
            for (int j = 0; j <= int'(dwell); j++) begin
                e = '{ready: 1'b0, busy: 1'b1, done: 1'b0, load: (j == 0), wave: wave,
                      ftw: 16'(pts[i])};
                exp_q.push_back(e);
            end
        end
        e = '{ready: 1'b0, busy: 1'b0, done: 1'b1, load: 1'b0, wave: wave,
              ftw: 16'(pts[pts.size()-1])};
        exp_q.push_back(e);
        e.ready = 1'b1;
        e.done  = 1'b0;
        exp_q.push_back(e);
    endtask

    // Single-shot sweep; cfg inputs are scrambled and cfg_valid toggled while busy.
    task automatic run_sweep(input logic [15:0] start, input logic [15:0] stop,
                             input logic [15:0] step, input logic [15:0] dwell,
                             input logic [1:0] wave, input logic abort_at_accept,
                             input string name);
        exp_t act;
        build_trace(start, stop, step, dwell, wave);
        @(posedge DAC_clk); #1;
        bus.cfg_ftw_start = start;
        bus.cfg_ftw_stop  = stop;
        bus.cfg_ftw_step  = step;
        bus.cfg_dwell     = dwell;
        bus.cfg_wave      = wave_t'(wave);
        bus.cfg_loop      = 1'b0;
        bus.cfg_valid     = 1'b1;
        bus.abort         = abort_at_accept;
        @(negedge DAC_clk);
        n_tests++;
        if (bus.cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s accept: cfg_ready=%b expected 1", name, bus.cfg_ready);
        end
        @(posedge DAC_clk); #1;
        bus.cfg_valid = 1'b0;
        bus.abort     = 1'b0;
        scramble_cfg();
        for (int k = 0; k < exp_q.size(); k++) begin
            @(negedge DAC_clk);
            act = {bus.cfg_ready, bus.busy, bus.done, bus.ftw_load, bus.wave_sel, bus.ftw};
            n_tests++;
            if (act !== exp_q[k]) begin
                n_fail++;
                $display("FAIL %s cycle %0d: got rdy=%b busy=%b done=%b load=%b wave=%0d ftw=%h, expected rdy=%b busy=%b done=%b load=%b wave=%0d ftw=%h",
                         name, k, act.ready, act.busy, act.done, act.load, act.wave, act.ftw,
                         exp_q[k].ready, exp_q[k].busy, exp_q[k].done, exp_q[k].load,
                         exp_q[k].wave, exp_q[k].ftw);
            end
            if (k + 1 < exp_q.size()) begin
                @(posedge DAC_clk); #1;
                bus.cfg_valid = exp_q[k+1].ready ? 1'b0 : 1'($urandom);
                scramble_cfg();
            end
        end
        bus.cfg_valid = 1'b0;
        last_ftw = exp_q[exp_q.size()-1].ftw;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if ({bus.cfg_ready, bus.busy, bus.done, bus.ftw_load, bus.wave_sel, bus.ftw} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_state: rdy=%b busy=%b done=%b load=%b wave=%0d ftw=%h, expected 1/0/0/0/0/0000",
                     bus.cfg_ready, bus.busy, bus.done, bus.ftw_load, bus.wave_sel, bus.ftw);
        end
        #10 DAC_rst_n = 1'b1;
    endtask

    task automatic test_idle_no_load();
        for (int i = 0; i < 8; i++) begin
            @(posedge DAC_clk); #1;
            bus.abort = 1'($urandom);
            @(negedge DAC_clk);
            n_tests++;
            if ({bus.ftw_load, bus.busy, bus.cfg_ready} !== 3'b001) begin
                n_fail++;
                $display("FAIL idle_no_load: load=%b busy=%b rdy=%b expected 0/0/1",
                         bus.ftw_load, bus.busy, bus.cfg_ready);
            end
        end
        bus.abort = 1'b0;
    endtask

    task automatic test_single_sweep();
        run_sweep(16'd100, 16'd130, 16'd10, 16'd3, 2'(SAW), 1'b0, "single_sweep");
    endtask

    task automatic test_saturation();
        run_sweep(16'd0, 16'd25, 16'd10, 16'd0, 2'(SQUARE), 1'b0, "saturate");
        run_sweep(16'hFFF0, 16'hFFFF, 16'h0020, 16'd1, 2'(TRI), 1'b0, "overflow");
    endtask

    task automatic test_degenerate();
        run_sweep(16'd500, 16'd100, 16'd7, 16'd2, 2'(RSVD), 1'b0, "start_ge_stop");
        run_sweep(16'd5, 16'd9, 16'd0, 16'd1, 2'(SAW), 1'b0, "step_zero");
    endtask

    task automatic test_abort_in_idle();
        run_sweep(16'd10, 16'd12, 16'd1, 16'd0, 2'(TRI), 1'b1, "abort_in_idle");
    endtask

    task automatic test_loop_abort();
        logic [15:0] pts [3];
        logic stop_flag = 1'b0;
        pts[0] = 16'd0; pts[1] = 16'd10; pts[2] = 16'd20;
        @(posedge DAC_clk); #1;
        bus.cfg_ftw_start = 16'd0;
        bus.cfg_ftw_stop  = 16'd20;
        bus.cfg_ftw_step  = 16'd10;
        bus.cfg_dwell     = 16'd1;
        bus.cfg_wave      = SAW;
        bus.cfg_loop      = 1'b1;
        bus.cfg_valid     = 1'b1;
        @(posedge DAC_clk); #1;
        bus.cfg_valid = 1'b0;
        scramble_cfg();
        @(negedge DAC_clk);
        n_tests++;
        if ({bus.busy, bus.ftw_load, bus.ftw} !== {1'b1, 1'b0, last_ftw}) begin
            n_fail++;
            $display("FAIL loop_load: busy=%b load=%b ftw=%h expected 1/0/%h",
                     bus.busy, bus.ftw_load, bus.ftw, last_ftw);
        end
        for (int it = 0; it < 3; it++) begin
            for (int p = 0; p < 3; p++) begin
                for (int j = 0; j < 2; j++) begin
                    if (!stop_flag) begin
                        @(posedge DAC_clk); #1;
                        if (it == 2 && p == 1 && j == 1) bus.abort = 1'b1;
                        @(negedge DAC_clk);
                        n_tests++;
                        if ({bus.busy, bus.done, bus.ftw_load, bus.ftw} !==
                            {1'b1, 1'b0, (j == 0), pts[p]}) begin
                            n_fail++;
                            $display("FAIL loop it%0d pt%0d c%0d: busy=%b done=%b load=%b ftw=%h expected 1/0/%b/%h",
                                     it, p, j, bus.busy, bus.done, bus.ftw_load, bus.ftw,
                                     (j == 0), pts[p]);
                        end
                        if (bus.abort) stop_flag = 1'b1;
                    end
                end
            end
        end
        @(posedge DAC_clk); #1;
        bus.abort = 1'b0;
        @(negedge DAC_clk);
        n_tests++;
        if ({bus.ftw, bus.ftw_load, bus.busy, bus.done, bus.cfg_ready} !==
            {16'h0, 1'b1, 1'b0, 1'b0, 1'b1}) begin
            n_fail++;
            $display("FAIL abort_response: ftw=%h load=%b busy=%b done=%b rdy=%b expected 0000/1/0/0/1",
                     bus.ftw, bus.ftw_load, bus.busy, bus.done, bus.cfg_ready);
        end
        @(posedge DAC_clk); #1;
        @(negedge DAC_clk);
        n_tests++;
        if ({bus.ftw, bus.ftw_load, bus.busy, bus.done} !== {16'h0, 1'b0, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL abort_idle: ftw=%h load=%b busy=%b done=%b expected 0000/0/0/0",
                     bus.ftw, bus.ftw_load, bus.busy, bus.done);
        end
        last_ftw = 16'h0;
    endtask

    task automatic test_reset_mid_sweep();
        @(posedge DAC_clk); #1;
        bus.cfg_ftw_start = 16'd1000;
        bus.cfg_ftw_stop  = 16'd2000;
        bus.cfg_ftw_step  = 16'd1;
        bus.cfg_dwell     = 16'd50;
        bus.cfg_wave      = TRI;
        bus.cfg_loop      = 1'b0;
        bus.cfg_valid     = 1'b1;
        @(posedge DAC_clk); #1;
        bus.cfg_valid = 1'b0;
        repeat (6) @(posedge DAC_clk);
        #3;
        DAC_rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.cfg_ready, bus.busy, bus.done, bus.ftw_load, bus.wave_sel, bus.ftw} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_async: rdy=%b busy=%b done=%b load=%b wave=%0d ftw=%h expected 1/0/0/0/0/0000",
                     bus.cfg_ready, bus.busy, bus.done, bus.ftw_load, bus.wave_sel, bus.ftw);
        end
        repeat (2) @(negedge DAC_clk);
        n_tests++;
        if ({bus.cfg_ready, bus.busy, bus.done, bus.ftw_load, bus.ftw} !==
            {1'b1, 1'b0, 1'b0, 1'b0, 16'h0}) begin
            n_fail++;
            $display("FAIL reset_hold: rdy=%b busy=%b done=%b load=%b ftw=%h expected 1/0/0/0/0000",
                     bus.cfg_ready, bus.busy, bus.done, bus.ftw_load, bus.ftw);
        end
        DAC_rst_n = 1'b1;
        last_ftw = 16'h0;
        run_sweep(16'd7, 16'd9, 16'd1, 16'd0, 2'(SAW), 1'b0, "after_reset");
    endtask

    task automatic test_random();
        logic [15:0] start, stop, step, dwell;
        for (int n = 0; n < 20; n++) begin
            start = 16'($urandom);
            if ($urandom_range(0, 3) == 0) start = 16'hFF00 | 16'($urandom_range(0, 255));
            stop  = (int'(start) + int'($urandom_range(0, 150)) > 65535) ? 16'hFFFF
                    : start + 16'($urandom_range(0, 150));
            if ($urandom_range(0, 4) == 0) stop = start - 16'($urandom_range(0, 50));
            step  = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'($urandom_range(0, 60));
            dwell = 16'($urandom_range(0, 3));
            run_sweep(start, stop, step, dwell, 2'($urandom_range(0, 3)), 1'b0, "random");
        end
    endtask

    initial begin
        DAC_rst_n         = 1'b0;
        bus.cfg_valid     = 1'b0;
        bus.abort         = 1'b0;
        bus.cfg_ftw_start = '0;
        bus.cfg_ftw_stop  = '0;
        bus.cfg_ftw_step  = '0;
        bus.cfg_dwell     = '0;
        bus.cfg_wave      = SQUARE;
        bus.cfg_loop      = 1'b0;
        test_reset();
        test_idle_no_load();
        test_single_sweep();
        test_saturation();
        test_degenerate();
        test_abort_in_idle();
        test_loop_abort();
        test_reset_mid_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_sweep_ctrl.md
# dds_sweep_ctrl

Frequency-sweep controller for the DDS waveform generator. Accepts a sweep configuration over a valid/ready handshake, then drives the DDS phase-accumulator tuning word (FTW) and waveform select. It steps the FTW from a start value to a stop value in fixed increments, holding each point for a programmable dwell time. Runs single-shot or in continuous loop, and supports abort. Sits between the host/register interface and the DDS datapath, in the `DAC_clk` domain.

## Interface

Parameters:
- `FTW_W`, default 16: tuning-word width; matches the DDS phase accumulator.
- `DWELL_W`, default 16: dwell counter width.

Ports:
- `DAC_clk`, in, 1: the single clock.
- `DAC_rst_n`, in, 1: asynchronous, active-low reset.
- `cfg_valid`, in, 1: configuration offered.
- `cfg_ready`, out, 1: controller can accept a configuration.
- `cfg_ftw_start`, in, FTW_W: first FTW of the sweep.
- `cfg_ftw_stop`, in, FTW_W: last FTW, inclusive.
- `cfg_ftw_step`, in, FTW_W: unsigned increment.
- `cfg_dwell`, in, DWELL_W: each point is held for `cfg_dwell`+1 cycles.
- `cfg_wave`, in, 2: waveform select, `wave_t`.
- `cfg_loop`, in, 1: 0 = single-shot, 1 = restart at start until aborted.
- `abort`, in, 1: level-sampled request to stop the sweep.
- `ftw`, out, FTW_W: registered tuning word to the DDS.
- `wave_sel`, out, 2: registered waveform select.
- `ftw_load`, out, 1: one-cycle strobe, high in the first cycle each new `ftw` value is valid.
- `busy`, out, 1: sweep in progress.
- `done`, out, 1: one-cycle pulse when a single-shot sweep completes.

## Operation

- States:
  - IDLE: `cfg_ready`=1.
  - LOAD: one cycle; sets `ftw` to start.
  - DWELL: holds the current point.
  - DONE: one cycle; pulses `done`.
- IDLE → LOAD:
  - Transition on `cfg_valid` && `cfg_ready`.
  - All cfg fields are latched on that edge. Later changes on the cfg inputs have no effect.
  - `wave_sel` updates on that same edge.
- LOAD → DWELL:
  - `ftw` ← start and `ftw_load` pulses.
  - Dwell counter ← `cfg_dwell`.
- DWELL with counter ≠ 0: decrement the counter.
- DWELL with counter = 0, end test is `ftw` ≥ stop (unsigned):
  - If not at the end: `ftw` ← min(`ftw`+step, stop). The sum is computed at FTW_W+1 bits, so carry-out counts as exceeding stop, which saturates to stop.
  - If not at the end and step = 0: `ftw` ← stop.
  - After any such update: `ftw_load` pulses and the counter reloads.
  - At the end with `cfg_loop`=0: go to DONE; `ftw` holds the stop value.
  - At the end with `cfg_loop`=1: `ftw` ← start, `ftw_load` pulses, counter reloads, and the state stays in DWELL. The restart is seamless, with no LOAD cycle and no `done`.
- start ≥ stop: the sweep is exactly one point at start, which is valid.
- DONE → IDLE unconditionally. `ftw` and `wave_sel` keep their last values.
- `abort` in LOAD, DWELL or DONE:
  - Next state is IDLE.
  - `ftw` ← 0 with an `ftw_load` pulse, which mutes the DDS output.
  - `done` is not asserted.
  - `abort` has priority over every other transition.
- `abort` in IDLE is ignored. A simultaneous `cfg_valid` is still accepted.
- Output decode:
  - `busy` = state ∈ {LOAD, DWELL}.
  - `cfg_ready` = state == IDLE.
  - Both are decoded from registered state, so there is no combinational path from the inputs.

## Timing

- Reset (asynchronous assert):
  - State = IDLE, `ftw`=0, `wave_sel`=0, `ftw_load`=0, `busy`=0, `done`=0.
  - `cfg_ready`=1 while in reset and after release.
- Handshake accepted in cycle 0:
  - LOAD in cycle 1.
  - `ftw`=start and `ftw_load`=1 in cycle 2.
  - Each point is held exactly `cfg_dwell`+1 cycles, counting from its `ftw_load` cycle.
- Single-shot `done`: the cycle after the last point's final dwell cycle. `cfg_ready`=1 the cycle after that.
- Abort sampled in cycle k: `ftw`=0, `ftw_load`=1 and state IDLE in cycle k+1.
- Reset mid-sweep returns all outputs to their reset values immediately. No partial `done` is produced.

## Structure

- `dds_pkg` holds:
  - `state_t` = IDLE, LOAD, DWELL, DONE.
  - `wave_t` = SQUARE 0, SAW 1, TRI 2, RSVD 3. RSVD passes through unchanged.
  - Default widths.
- One sub-module, `dds_dwell_timer`:
  - Loadable down-counter: load, enable, zero flag.
  - Instantiated once.
- Next-FTW saturating adder and end compare stay inline in `dds_sweep_ctrl`.

## Test plan

- Single sweep, start=100, stop=130, step=10, dwell=3, wave=SAW → `ftw` 100/110/120/130, each 4 cycles; 4 `ftw_load` pulses; `wave_sel`=1; `done` for 1 cycle right after the 16th held cycle; `cfg_ready` 1 cycle later.
- Saturation, start=0, stop=25, step=10, dwell=0 → `ftw` 0, 10, 20, 25, then `done`. Width overflow, start=0xFFF0, stop=0xFFFF, step=0x20 → `ftw` 0xFFF0 then 0xFFFF, then `done`.
- Degenerate cases:
  - start=500, stop=100 → a single point 500 held `cfg_dwell`+1 cycles, then `done`.
  - step=0, start=5, stop=9 → 5, 9, then `done`.
- Loop, start=0, stop=20, step=10, dwell=1 → 0, 10, 20, 0, 10… with no `done`. Abort during the point 10 → next cycle `ftw`=0, `ftw_load`=1, `busy`=0.
- Reset behaviour:
  - Assert `DAC_rst_n` low mid-DWELL, between clock edges → outputs reset immediately.
  - After release, a new cfg is accepted in the first cycle.
  - `cfg_valid` held low in IDLE → no `ftw_load`.
- Cfg handling:
  - `cfg_valid` asserted while busy → not accepted (`cfg_ready`=0); the sweep is unaffected.
  - Cfg inputs changed mid-sweep → no effect.
